muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_shift_core.sv | 30 +++
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, state encoding and helpers for the RV32M multiply/divide unit
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int ITER_CYCLES = 32;
    localparam int LAT_ITER    = 34;
    localparam int LAT_SPECIAL = 1;

    function automatic logic [63:0] apply_sign64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    // MUL keeps the low word; every high-word variant takes [63:32].
    function automatic logic [31:0] mul_select(input logic [63:0] p, input logic [2:0] f);
        return (f == F3_MUL) ? p[31:0] : p[63:32];
    endfunction

endpackage

// File: rtl/muldiv_shift_core.sv
// rtl/muldiv_shift_core.sv - one iteration of the shared 64-bit shift-add multiply / restoring divide datapath
module muldiv_shift_core
    import muldiv_pkg::*;
(
    input  logic        is_div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] mcand_i,
    output logic [63:0] acc_o
);

    logic [32:0] add_sum;
    logic [33:0] sub_diff;

    // Multiply: acc = {partial, multiplier}, shifted right. Divide: acc = {remainder, quotient}, shifted left.
    always_comb begin
        add_sum  = {1'b0, acc_i[63:32]} + {1'b0, mcand_i};
        sub_diff = {1'b0, acc_i[63:31]} - {2'b00, mcand_i};
        acc_o    = {1'b0, acc_i[63:1]};
        if (is_div_i) begin
            if (!sub_diff[33]) begin
                acc_o = {sub_diff[31:0], acc_i[30:0], 1'b1};
            end else begin
                acc_o = {acc_i[62:0], 1'b0};
            end
        end else if (acc_i[0]) begin
            acc_o = {add_sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M multiply/divide unit; MULDIV_FAST_MUL_EN selects a single-cycle multiply
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d, acc_step;
    logic [31:0] mcand_q, mcand_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        neg_q, neg_d;
    logic [31:0] result_q, result_d;

    logic        is_div, op1_signed, op2_signed, op1_neg, op2_neg, req_neg;
    logic        div_zero, div_ovf;
    logic [31:0] op1_mag, op2_mag, div_sel;
    logic [63:0] prod_fixed;

    assign is_div     = funct3[2];
    assign op1_signed = is_div ? ~funct3[0] : (funct3 != F3_MULHU);
    assign op2_signed = is_div ? ~funct3[0] : (funct3 == F3_MUL || funct3 == F3_MULH);
    assign op1_neg    = op1_signed & op1[31];
    assign op2_neg    = op2_signed & op2[31];
    assign op1_mag    = op1_neg ? (~op1 + 32'd1) : op1;
    assign op2_mag    = op2_neg ? (~op2 + 32'd1) : op2;
    // Remainder follows the dividend's sign; quotient and product follow the XOR.
    assign req_neg    = (is_div && funct3[1]) ? op1_neg : (op1_neg ^ op2_neg);
    assign div_zero   = is_div && (op2 == 32'd0);
    assign div_ovf    = (funct3 == F3_DIV || funct3 == F3_REM)
                        && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod;
    assign fast_prod = apply_sign64({32'd0, op1_mag} * {32'd0, op2_mag}, req_neg);
`endif

    assign prod_fixed = apply_sign64(acc_q, neg_q);
    assign div_sel    = funct3_q[1] ? acc_q[63:32] : acc_q[31:0];

    muldiv_shift_core u_core (
        .is_div_i (funct3_q[2]),
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    funct3_d = funct3;
                    neg_d    = req_neg;
                    mcand_d  = is_div ? op2_mag : op1_mag;
                    acc_d    = {32'd0, is_div ? op1_mag : op2_mag};
                    if (div_zero) begin
                        result_d = funct3[1] ? op1 : 32'hFFFF_FFFF;
                        state_d  = ST_DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? 32'd0 : op1;
                        state_d  = ST_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div) begin
                        result_d = mul_select(fast_prod, funct3);
                        state_d  = ST_DONE;
                    end
`endif
                    else begin
                        cnt_d   = 5'(ITER_CYCLES - 1);
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                if (cnt_q == 5'd0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_FIX: begin
                if (funct3_q[2]) begin
                    result_d = neg_q ? (~div_sel + 32'd1) : div_sel;
                end else begin
                    result_d = mul_select(prod_fixed, funct3_q);
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            mcand_q  <= 32'd0;
            funct3_q <= 3'd0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] op1, op2, result;
    logic [2:0]  funct3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        int              ia, ib;
        bit              ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin sp = sa * sb;           return sp[31:0];  end
            3'b001: begin sp = sa * sb;           return sp[63:32]; end
            3'b010: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'b011: begin up = ua * ub;           return up[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit ovf;
        ovf = (f == 3'b100 || f == 3'b110) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1'b1;
`endif
        return f[2] && ((b == 32'd0) || ovf);
    endfunction

    function automatic bit no_busy(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && is_special(f, a, b);
    endfunction

    // Compare process: scoreboard of one outstanding operation, sampled mid-cycle.
    bit          pending = 1'b0;
    bit          seen_valid, exp_nobusy;
    logic [31:0] exp_res;
    int          exp_lat, lat_cnt;

    always @(negedge clk) begin
        if (rst) begin
            chk(!out_valid, "reset_out_valid", 32'(out_valid), 32'd0);
            chk(!busy, "reset_busy", 32'(busy), 32'd0);
            chk(result == 32'd0, "reset_result", result, 32'd0);
            pending = 1'b0;
        end else begin
            if (pending) begin
                lat_cnt++;
                if (exp_nobusy) chk(!busy, "busy_special", 32'(busy), 32'd0);
                if (out_valid) begin
                    if (!seen_valid) begin
                        chk(lat_cnt == exp_lat, "latency", 32'(lat_cnt), 32'(exp_lat));
                        seen_valid = 1'b1;
                    end
                    chk(result == exp_res, "result", result, exp_res);
                    chk(!in_ready, "in_ready_done", 32'(in_ready), 32'd0);
                    if (out_ready) pending = 1'b0;
                end else if (seen_valid) begin
                    chk(1'b0, "out_valid_dropped", 32'd0, 32'd1);
                end
            end else begin
                chk(!out_valid, "spurious_valid", 32'(out_valid), 32'd0);
            end
            if (in_valid && in_ready) begin
                pending    = 1'b1;
                seen_valid = 1'b0;
                lat_cnt    = 0;
                exp_res    = model(funct3, op1, op2);
                exp_lat    = is_special(funct3, op1, op2) ? 1 : 34;
                exp_nobusy = no_busy(funct3, op1, op2);
            end
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input int stall);
        int n;
        @(posedge clk); #1;
        chk(model(f, a, b) == lit, "model_ref", model(f, a, b), lit);
        op1       = a;
        op2       = b;
        funct3    = f;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op1      = $urandom;
        op2      = $urandom;
        funct3   = 3'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(out_valid, "timeout", 32'(n), 32'd100);
        if (stall > 0) begin
            in_valid = 1'b1;
            op1      = 32'd9;
            op2      = 32'd3;
            funct3   = 3'b101;
            repeat (stall) begin
                @(posedge clk); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk(!out_valid && in_ready, "release", {30'd0, out_valid, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic reset_mid_div();
        @(posedge clk); #1;
        op1      = 32'd1000;
        op2      = 32'd7;
        funct3   = 3'b100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk(in_ready, "in_ready_after_rst", 32'(in_ready), 32'd1);
        repeat (40) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op1       = 32'd0;
        op2       = 32'd0;
        funct3    = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk(in_ready, "in_ready_reset", 32'(in_ready), 32'd1);

        run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op(3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        run_op(3'b011, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        run_op(3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 0);
        run_op(3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         0);
        run_op(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         0);
        run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op(3'b010, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op(3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        run_op(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        run_op(3'b101, 32'd100,        32'd7,         32'd14,        0);
        run_op(3'b111, 32'd100,        32'd7,         32'd2,         0);
        run_op(3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        run_op(3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         0);
        run_op(3'b100, 32'h8000_0000,  32'd1,         32'h8000_0000, 0);
        run_op(3'b110, 32'h8000_0000,  32'd3,         32'hFFFF_FFFE, 0);
        run_op(3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 0);
        run_op(3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_op(3'b111, 32'd5,          32'd0,         32'd5,         0);
        run_op(3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_op(3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 0);
        run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
        run_op(3'b101, 32'd100,        32'd7,         32'd14,        5);
        run_op(3'b111, 32'd5,          32'd0,         32'd5,         5);

        reset_mid_div();
        run_op(3'b000, 32'd3,          32'd4,         32'd12,        0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
